// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus optional iterative mul/divu/remu (ALU_SEQ_MULDIV_EN).
// Ports: clk, rst_n, in_valid/in_ready + a, b, op in; out_valid/out_ready + result, is_zero, busy out.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             is_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_d;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_d = a + b;
    case (op)
      4'd1:    alu_d = a - b;
      4'd2:    alu_d = a ^ b;
      4'd3:    alu_d = a << shamt;
      4'd4:    alu_d = a >> shamt;
      4'd5:    alu_d = a & b;
      4'd6:    alu_d = a | b;
      4'd7:    alu_d = {{(WIDTH-1){1'b0}}, a < b};
      4'd8:    alu_d = $unsigned($signed(a) >>> shamt);
      4'd9:    alu_d = {{(WIDTH-1){1'b0}},
                        $signed(a) < $signed(b)};
      default: alu_d = a + b;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [WIDTH-1:0] x_d, y_d, acc_d, fin_d;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH:0]   div_t;
  logic             div_ge;
  logic             md_go;

  assign md_go = (op == 4'd10) || (op == 4'd11)
              || (op == 4'd12);

  // mul: acc += x when y[0]; x <<= 1; y >>= 1.
  // div: acc is the partial remainder, x shifts
  // the dividend out and quotient bits in.
  // A zero divisor yields q=all ones, r=a.
  always_comb begin
    div_t  = {acc_q, x_q[WIDTH-1]};
    div_ge = div_t >= {1'b0, y_q};
    if (op_q == 4'd10) begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
      fin_d = acc_d;
    end else begin
      acc_d = div_ge ? div_t[WIDTH-1:0] - y_q
                     : div_t[WIDTH-1:0];
      x_d   = {x_q[WIDTH-2:0], div_ge};
      y_d   = y_q;
      fin_d = (op_q == 4'd11) ? x_d : acc_d;
    end
  end

  assign busy = (state_q == BUSY);
`else
  assign busy = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign is_zero   = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (md_go) begin
              state_q <= BUSY;
              x_q     <= a;
              y_q     <= b;
              acc_q   <= '0;
              op_q    <= op;
              cnt_q   <= '0;
            end else begin
`else
            begin
`endif
              state_q  <= DONE;
              result_q <= alu_d;
              zero_q   <= (alu_d == '0);
            end
          end
        end
        BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
          x_q   <= x_d;
          y_q   <= y_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + SHW'(1);
          // last step commits straight into DONE
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            result_q <= fin_d;
            zero_q   <= (fin_d == '0);
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random ops against a plain-arithmetic model.
// Covers reset, latency, back-pressure, divide-by-zero and mid-op reset.
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         is_zero;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .is_zero(is_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_md(input logic [3:0] o);
    return MD && (o >= 4'd10) && (o <= 4'd12);
  endfunction

  function automatic logic [W-1:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y,
    input logic [3:0] o);
    logic [3:0] e;
    int sh;
    e  = o;
    sh = int'(y % W);
    if (!MD && e >= 4'd10 && e <= 4'd12) e = 4'd0;
    case (e)
      4'd1:  return x - y;
      4'd2:  return x ^ y;
      4'd3:  return x << sh;
      4'd4:  return x >> sh;
      4'd5:  return x & y;
      4'd6:  return x | y;
      4'd7:  return (x < y) ? 32'd1 : 32'd0;
      4'd8:  return $unsigned($signed(x) >>> sh);
      4'd9:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd10: return x * y;
      4'd11: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd12: return (y == 0) ? x : x % y;
      default: return x + y;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb_,
                        input logic [3:0]   top,
                        input bit           hold,
                        input int           stall,
                        input string        tag);
    logic [W-1:0] exp;
    int  lat, explat, guard;
    bit  md, busy_ok, rdy_ok, stab_ok;
    exp    = model(ta, tb_, top);
    md     = is_md(top);
    explat = md ? W + 1 : 1;
    guard  = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, "/idle"}, {31'b0, in_ready}, 32'd1);
    a = ta; b = tb_; op = top;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 1; busy_ok = 1; rdy_ok = 1;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_ok = 0;
      if (in_ready) rdy_ok = 0;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    chk({tag, "/lat"}, 32'(lat), 32'(explat));
    if (md) chk({tag, "/busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "/rdy"}, {31'b0, rdy_ok}, 32'd1);
    chk({tag, "/res"}, result, exp);
    chk({tag, "/zero"}, {31'b0, is_zero},
        {31'b0, exp == 0});
    chk({tag, "/nbusy"}, {31'b0, busy}, 32'd0);
    if (stall > 0) begin
      stab_ok = 1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (!out_valid || result !== exp || in_ready)
          stab_ok = 0;
      end
      chk({tag, "/hold"}, {31'b0, stab_ok}, 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "/back"}, {29'b0, in_ready, out_valid, busy},
        32'b100);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/flags", {28'b0, in_ready, out_valid, is_zero, busy},
        32'b1010);
    chk("rst/res", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'd5, 32'd3, 4'd0, 0, 0, "add");
    run_op(32'd7, 32'd7, 4'd1, 0, 0, "sub");
    run_op(32'h8000_0000, 32'h24, 4'd8, 0, 0, "sra");
    run_op(32'hFFFF_FFFF, 32'd1, 4'd9, 0, 0, "slt");
    run_op(32'hFFFF_FFFF, 32'd1, 4'd7, 0, 0, "sltu");
    run_op(32'h0001_0001, 32'h10, 4'd10, 1, 0, "mul");
    run_op(32'd100, 32'd7, 4'd11, 0, 0, "divu");
    run_op(32'd100, 32'd7, 4'd12, 0, 0, "remu");
    run_op(32'd5, 32'd0, 4'd11, 0, 0, "divu0");
    run_op(32'd5, 32'd0, 4'd12, 0, 0, "remu0");
    run_op(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2, 0, 10, "xor");
    run_op(32'h1234_5678, 32'd0, 4'd14, 0, 0, "op14");

    a = 32'h0001_0001; b = 32'd16; op = 4'd10;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    if (MD) chk("mrst/pre", {31'b0, busy}, 32'd1);
    else    chk("mrst/pre", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst/flags", {28'b0, in_ready, out_valid, is_zero, busy},
        32'b1010);
    chk("mrst/res", result, 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    run_op(32'd40, 32'd2, 4'd0, 0, 0, "add2");
    run_op(32'd2, 32'd3, 4'd10, 0, 0, "mul23");

    for (int k = 0; k < 40; k++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ?
            32'($urandom_range(0, 3)) : $urandom;
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, 0, (k % 5 == 0) ? 3 : 0,
             $sformatf("rnd%0d_op%0d", k, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath's combinational ALU. Width is set by a parameter and the opcode space is widened to 4 bits.
- Adds arithmetic shift and signed compare, plus iterative multiply, divide and remainder.
- Sits between register read and writeback. Each operation is accepted on a valid/ready input and returned on a valid/ready output with a registered result and zero flag.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), number of low b bits used as the shift amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  source 1.
- b  input  WIDTH  source 2.
- op  input  4  function select.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- is_zero  output  1  registered (result == 0).
- busy  output  1  iterative operation in progress.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, result = 0, is_zero = 1, busy = 0. All internal counters and partial registers are cleared.
- Opcodes:
  - 0 add; 1 sub; 2 xor; 3 sll; 4 srl; 5 and; 6 or.
  - 7 sltu: result = 1 if a < b unsigned, else 0.
  - 8 sra; 9 slt (signed compare).
  - 10 mul: low WIDTH bits of the unsigned product.
  - 11 divu: unsigned quotient.
  - 12 remu: unsigned remainder.
  - 13-15: treated as add.
- Shifts use b[SHW-1:0] only. All arithmetic wraps modulo 2^WIDTH.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = 1 only in IDLE.
  - An operation is accepted on a cycle where in_valid && in_ready; a, b and op are captured on that edge.
- Single-cycle ops (0-9 and 13-15): IDLE -> DONE. result is valid one cycle after acceptance (latency 1).
- mul (op 10):
  - IDLE -> BUSY; busy = 1.
  - Shift-add, one bit per cycle over WIDTH cycles, then -> DONE.
  - out_valid asserts exactly WIDTH+1 cycles after acceptance.
- divu/remu (ops 11/12):
  - Restoring division, one quotient bit per cycle.
  - Same timing as mul: WIDTH cycles in BUSY, out_valid at WIDTH+1 cycles after acceptance.
- Divide by zero: quotient = all ones, remainder = a. Still takes the full WIDTH cycles, with no early exit.
- DONE:
  - out_valid = 1; result and is_zero are held stable until out_valid && out_ready.
  - On that handshake edge -> IDLE; out_valid drops the next cycle and in_ready rises.
  - If out_ready is already high when DONE is entered, the handshake completes on the first DONE cycle.
- Throughput: no new operation is accepted in BUSY or DONE, so in_valid is ignored there. Maximum rate is one single-cycle op per 2 cycles.
- result and is_zero change only on the transition into DONE.
- Reset mid-operation (BUSY or DONE): the operation is abandoned with no output. The block returns to the reset values above.
- Back-pressure: out_ready low in DONE holds the block indefinitely; in_ready stays 0.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: ops 10-12 are implemented as above and busy is functional.
- Undefined:
  - No multiply/divide datapath is synthesised; ops 10-12 execute as add with latency 1.
  - busy is tied to 0 and BUSY is never entered.

Test Plan:
- Reset, then add a=32'h0000_0005, b=32'h0000_0003 (WIDTH=32), out_ready=1 -> out_valid 1 cycle after accept, result=8, is_zero=0, in_ready back to 1 the following cycle.
- sub a=7, b=7 -> result=0, is_zero=1. sra a=32'h8000_0000, b=32'h0000_0024 (shift 4) -> 32'hF800_0000. slt a=-1, b=1 -> 1; sltu with the same operands -> 0.
- mul a=32'h0001_0001, b=32'h0000_0010 -> busy high for 32 cycles, out_valid at cycle 33 after accept, result=32'h0010_0010; in_valid held high during BUSY is not accepted.
- divu a=100, b=7 -> 14; remu a=100, b=7 -> 2. divu a=5, b=0 -> 32'hFFFF_FFFF; remu a=5, b=0 -> 5; both at cycle 33.
- Hold out_ready=0 for 10 cycles after an xor result (a=32'hFF00_FF00, b=32'h0F0F_0F0F -> 32'hF00F_F00F) -> result and out_valid stable; in_ready=0 until the handshake.
- Assert rst_n=0 at BUSY cycle 12 of a mul -> immediately out_valid=0, busy=0, result=0, in_ready=1; a following add completes normally. Repeat with ALU_SEQ_MULDIV_EN undefined: mul a=2, b=3 -> result=5, latency 1.
